// File: rtl/fifo_stream_reader.sv
// FIFO read-side master: drains a 1-cycle-latency FIFO read port into a
// 2-entry buffer and presents it as a valid/ready stream with burst framing.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   enable_i               permits new FIFO reads
//   fifo_empty_i           FIFO empty flag
//   fifo_data_i            FIFO read data (cycle after fifo_rd_en_o)
//   fifo_rd_en_o           FIFO read enable
//   m_valid_o/m_ready_i    stream handshake
//   m_data_o               stream data (buffer head)
//   m_last_o               last beat of each BURST_LEN burst
//   busy_o                 buffer non-empty or read in flight
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [CW-1:0]         r_beat_cnt;

  logic       w_pop;
  logic       w_cap;
  logic [2:0] w_credit;

  assign w_pop = m_valid_o && m_ready_i;
  assign w_cap = r_inflight;

  // Slots committed after this edge; a new read needs one free slot.
  assign w_credit = {1'b0, r_occ}
                  + {2'b0, r_inflight}
                  - {2'b0, w_pop};

  assign fifo_rd_en_o = rst_ni && enable_i
                     && !fifo_empty_i
                     && (w_credit < 3'd2);

  assign m_valid_o = (r_occ != 2'd0);
  assign m_data_o  = r_buf0;
  assign m_last_o  = m_valid_o && (r_beat_cnt == LAST);
  assign busy_o    = m_valid_o || r_inflight;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en_o;
      unique case ({w_cap, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= fifo_data_i;
          else               r_buf1 <= fifo_data_i;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Head leaves; new word lands behind whatever remains.
          if (r_occ == 2'd1) begin
            r_buf0 <= fifo_data_i;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      if (r_beat_cnt == LAST) r_beat_cnt <= '0;
      else                    r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: FIFO model plus a
// scoreboard of expected {last,data} beats checked on every pop.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       rd_en;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [0:1023];
  int wp = 0;
  int rp = 0;
  logic [8:0] exp_q[$];
  int exp_beat = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .enable_i(enable),
    .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data),
    .fifo_rd_en_o(rd_en),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_data_o(m_data),
    .m_last_o(m_last),
    .busy_o(busy)
  );

  assign fifo_empty = (rp == wp);

  // FIFO model: registered read, contents flushed while reset is held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp <= wp;
    end else if (rd_en) begin
      fifo_data <= mem[rp % 1024];
      rp <= rp + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got data=%h last=%b, none expected",
                 m_data, m_last);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({m_last, m_data} !== e) begin
          miscompares++;
          $display("FAIL pop_beat: got data=%h last=%b, want data=%h last=%b",
                   m_data, m_last, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic push_word(input logic [7:0] d);
    mem[wp % 1024] = d;
    wp = wp + 1;
    exp_q.push_back({(exp_beat == 3), d});
    exp_beat = (exp_beat + 1) % 4;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    exp_beat = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (exp_q.size() != 0 || busy) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d beats left busy=%b, want 0 and 0",
               nm, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    m_ready = 1'b1;
    mem[wp % 1024] = 8'hEE;
    wp = wp + 1;
    #1;
    vectors++;
    if ({rd_en, m_valid, m_data, m_last, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outs: got rd=%b v=%b d=%h l=%b b=%b, want all 0",
               rd_en, m_valid, m_data, m_last, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    int rd_cnt, v_cnt, rd_cyc, v_cyc;
    rd_cnt = 0; v_cnt = 0; rd_cyc = -1; v_cyc = -1;
    do_reset();
    m_ready = 1'b1;
    push_word(8'hA5);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_en) begin rd_cnt++; if (rd_cyc < 0) rd_cyc = i; end
      if (m_valid) begin v_cnt++; if (v_cyc < 0) v_cyc = i; end
    end
    vectors++;
    if (rd_cnt != 1 || v_cnt != 1) begin
      miscompares++;
      $display("FAIL single_counts: got rd=%0d valid=%0d, want 1 and 1",
               rd_cnt, v_cnt);
    end
    vectors++;
    if (v_cyc - rd_cyc != 2) begin
      miscompares++;
      $display("FAIL single_latency: got %0d, want 2", v_cyc - rd_cyc);
    end
    wait_drain("single");
  endtask

  task automatic test_streaming();
    int v_cnt, first, last;
    v_cnt = 0; first = -1; last = -1;
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (m_valid) begin
        v_cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    vectors++;
    if (v_cnt != 8 || first != 2 || last != 9) begin
      miscompares++;
      $display("FAIL stream_gapless: got n=%0d first=%0d last=%0d, want 8 2 9",
               v_cnt, first, last);
    end
    wait_drain("stream");
  endtask

  task automatic test_backpressure();
    int rd_cnt;
    bit moved;
    rd_cnt = 0; moved = 0;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i));
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_en) rd_cnt++;
      if (m_valid && m_data !== 8'h10) moved = 1;
    end
    vectors++;
    if (rd_cnt != 2) begin
      miscompares++;
      $display("FAIL bp_reads: got %0d, want 2", rd_cnt);
    end
    vectors++;
    if (moved || m_data !== 8'h10 || !m_valid) begin
      miscompares++;
      $display("FAIL bp_hold: got d=%h v=%b moved=%b, want 10 1 0",
               m_data, m_valid, moved);
    end
    vectors++;
    if (rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_rden: got %b, want 0", rd_en);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_empty_gap();
    int v_cnt;
    v_cnt = 0;
    do_reset();
    m_ready = 1'b1;
    push_word(8'h20);
    push_word(8'h21);
    enable = 1'b1;
    repeat (5) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_valid) v_cnt++;
    end
    vectors++;
    if (v_cnt != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_idle: got valid=%0d busy=%b, want 0 0", v_cnt, busy);
    end
    @(posedge clk);
    #1;
    push_word(8'h22);
    push_word(8'h23);
    wait_drain("gap");
  endtask

  task automatic test_enable_drop();
    int rd_cnt;
    rd_cnt = 0;
    do_reset();
    m_ready = 1'b1;
    push_word(8'h40);
    push_word(8'h41);
    enable = 1'b1;
    @(negedge clk);
    vectors++;
    if (rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL en_first_rd: got %b, want 1", rd_en);
    end
    @(posedge clk);
    #1 enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_en) rd_cnt++;
    end
    vectors++;
    if (rd_cnt != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL en_stop: got reads=%0d busy=%b, want 0 0", rd_cnt, busy);
    end
    vectors++;
    if (exp_q.size() != 1 || wp - rp != 1) begin
      miscompares++;
      $display("FAIL en_delivered: got left=%0d fifo=%0d, want 1 1",
               exp_q.size(), wp - rp);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    vectors++;
    if (!m_valid || !busy) begin
      miscompares++;
      $display("FAIL ar_pre: got v=%b b=%b, want 1 1", m_valid, busy);
    end
    #2 rst_n = 1'b0;
    exp_q.delete();
    exp_beat = 0;
    #1;
    vectors++;
    if ({rd_en, m_valid, m_data, m_last, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL ar_outs: got rd=%b v=%b d=%h l=%b b=%b, want all 0",
               rd_en, m_valid, m_data, m_last, busy);
    end
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i));
    m_ready = 1'b1;
    enable = 1'b1;
    wait_drain("ar");
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_empty_gap();
    test_enable_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
